// File: rtl/div_defs.sv
// Shared definitions for the restoring divider: default width, FSM encoding
// and the step-counter width helper.
package div_defs;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Wide enough to hold the final count of 2N steps.
    function automatic int cnt_w(input int n);
        return $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/div_if.sv
// Operand/result bundle of the divider; the requester drives ld/a/b and
// observes the result registers and status flags.
interface div_if #(
    parameter int N = div_defs::N_DEF
);
    logic             ld;
    logic [2*N-1:0]   a;
    logic [N-1:0]     b;
    logic [2*N-1:0]   rq;
    logic [N-1:0]     rr;
    logic [N-1:0]     rb;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (output ld, a, b, input rq, rr, rb, busy, done, dz);
    modport slave  (input ld, a, b, output rq, rr, rb, busy, done, dz);
endinterface

// File: rtl/div_step.sv
// One restoring-division bit: trial subtract of the divisor from the
// (N+1)-bit value {rr, next dividend bit}, restoring when it would go negative.
module div_step #(
    parameter int N = div_defs::N_DEF
) (
    input  logic [N-1:0] rr_i,
    input  logic         msb_i,
    input  logic [N-1:0] rb_i,
    output logic [N-1:0] rr_o,
    output logic         q_o
);
    logic [N:0] t;
    logic [N:0] diff;

    always_comb begin
        t    = {rr_i, msb_i};
        diff = t - {1'b0, rb_i};
        q_o  = (t >= {1'b0, rb_i});
        rr_o = q_o ? diff[N-1:0] : t[N-1:0];
    end
endmodule

// File: rtl/div.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per clock, with divide-by-zero short-circuit to DONE.
module div
    import div_defs::*;
#(
    parameter int N = N_DEF
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int CW = cnt_w(N);

    state_t          state_q, state_d;
    logic [2*N-1:0]  rq_q, rq_d;
    logic [N-1:0]    rr_q, rr_d;
    logic [N-1:0]    rb_q, rb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d;

    logic [N-1:0]    step_rr;
    logic            step_q;

    div_step #(.N(N)) u_step (
        .rr_i  (rr_q),
        .msb_i (rq_q[2*N-1]),
        .rb_i  (rb_q),
        .rr_o  (step_rr),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rq_q    <= '0;
            rr_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        // ld overrides every state, including an in-flight RUN.
        if (bus.ld) begin
            state_d = S_LOAD;
            rq_d    = bus.a;
            rr_d    = '0;
            rb_d    = bus.b;
            cnt_d   = '0;
            dz_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (rb_q != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                        rq_d    = '1;
                        rr_d    = '0;
                    end
                end
                S_RUN: begin
                    rr_d  = step_rr;
                    rq_d  = {rq_q[2*N-2:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(2 * N - 1)) state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.rq   = rq_q;
    assign bus.rr   = rr_q;
    assign bus.rb   = rb_q;
    assign bus.dz   = dz_q;
    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter N, default 4, divisor/remainder width; dividend/quotient width is 2N.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ld  input  1  1 = load operands and hold; 0 = divide.
REQ-005 a  input  2N  dividend.
REQ-006 b  input  N  divisor.
REQ-007 rq  output  2N  quotient / shifting dividend register.
REQ-008 rr  output  N  partial remainder register.
REQ-009 rb  output  N  latched divisor.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.
REQ-012 dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 FSM states IDLE, LOAD, RUN, DONE; the reset state is IDLE.
REQ-014 ld=1 at any edge, in any state, SHALL force LOAD.
- rq<=a, rr<=0, rb<=b, step counter<=0, dz<=0.
- ld has priority over every other transition.
REQ-015 LOAD with ld=0 and rb!=0 -> RUN.
REQ-016 LOAD with ld=0 and rb==0 -> DONE with dz=1, rq=all ones, rr=0; no RUN cycles.
REQ-017 Each RUN edge SHALL perform one restoring step on the (N+1)-bit trial value t={rr,rq[2N-1]}:
- if t>=rb: rr<=t-rb, rq<={rq[2N-2:0],1};
- else: rr<=t[N-1:0], rq<={rq[2N-2:0],0}.
REQ-018 The counter SHALL increment per RUN step; after exactly 2N steps -> DONE.
REQ-019 Latency: done rises at the 2N-th rising edge after the first edge that samples ld=0 in LOAD.
REQ-020 DONE SHALL hold rq, rr, rb, dz and done until ld=1 or reset.
REQ-021 IDLE with ld=0 SHALL remain IDLE with all registers unchanged.
REQ-022 Changes on a or b outside LOAD SHALL NOT affect the result.
REQ-023 Result: rq=floor(a/b), rr=a mod b for all a in [0,2^2N-1], b in [1,2^N-1].
REQ-024 busy=1 only in RUN; done=1 only in DONE; busy and done SHALL never both be 1.
REQ-025 The trial subtraction SHALL use N+1 bits so that t up to 2^(N+1)-1 compares correctly.

Reset
REQ-026 rst=0 SHALL immediately, without a clock edge, force state IDLE and clear rq, rr, rb, counter, busy, done and dz.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no partial result is retained.
REQ-028 After rst deasserts, the first edge with ld=1 SHALL load normally.

Structure
REQ-029 FSM state encodings and the default N SHALL live in a shared definitions package, div_defs.
REQ-030 One combinational sub-module, div_step, SHALL compute the trial subtract/restore for one bit; div instantiates it once.
REQ-031 All registers SHALL reside in div; the counter width SHALL be clog2(2N)+1.

Verification
REQ-032 a=100, b=7, ld 1->0 -> after 8 edges: done=1, rq=14, rr=2, dz=0; busy=1 for exactly 8 cycles.
REQ-033 a=255, b=1 -> rq=255, rr=0; a=5, b=15 -> rq=0, rr=5.
REQ-034 b=0, ld 1->0 -> the next edge gives done=1, dz=1, rq=8'hFF, rr=0, with busy never asserted.
REQ-035 a=200, b=9, then ld=1 reasserted at RUN step 3 with a=50, b=6, then released -> rq=8, rr=2 8 edges after release.
REQ-036 rst=0 pulsed mid-RUN (not clock-aligned) -> all outputs are 0 immediately; a subsequent load of 100/7 gives the correct result.
REQ-037 An exhaustive sweep over all a and all b=1..15 SHALL match the reference quotient and remainder, and done SHALL rise at exactly 8 edges each time.
